// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers. Arbitration is round-robin at
// message boundaries, and each byte is sequenced as pulse, wait for completion, then a gap.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 3,
  parameter int unsigned CHAR_GAP     = 100000,
  parameter int unsigned LOCK_TIMEOUT = 5000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   transmit,
  output logic [7:0]             tx_byte,
  input  logic                   is_transmitting,
  output logic [2:0]             grant_id,
  output logic                   locked,
  output logic                   busy,
  output logic                   timeout_evt
);

  localparam int unsigned GapW = (CHAR_GAP > 1) ? $clog2(CHAR_GAP) : 1;
  localparam int unsigned TmoW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [GapW-1:0] GapLast = (CHAR_GAP > 0) ? GapW'(CHAR_GAP - 1) : '0;
  localparam logic [TmoW-1:0] TmoLast = (LOCK_TIMEOUT > 0) ? TmoW'(LOCK_TIMEOUT - 1) : '0;
  localparam logic [2:0]      RrInit  = 3'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StPulse,
    StWaitStart,
    StWaitDone,
    StGap
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [2:0]      rr_q, rr_d;
  logic [7:0]      byte_q, byte_d;
  logic            locked_q, locked_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            evt_q, evt_d;

  // Requester vectors widened to the full 3-bit index space so any index selects cleanly.
  logic [7:0]  valid_pad;
  logic [7:0]  last_pad;
  logic [63:0] data_pad;

  assign valid_pad = 8'(req_valid);
  assign last_pad  = 8'(req_last);
  assign data_pad  = 64'(req_data);

  logic       sel_found;
  logic [2:0] sel_idx;
  logic [2:0] cand;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 3'((32'(rr_q) + k) % NUM_REQ);
      if (!sel_found && valid_pad[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    byte_d   = byte_q;
    locked_d = locked_q;
    gap_d    = gap_q;
    tmo_d    = tmo_q;
    evt_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A new byte is held off while the serializer is still busy, e.g. after a reset mid-frame.
        if (locked_q) begin
          if (valid_pad[grant_q]) begin
            tmo_d = '0;
            if (!is_transmitting) begin
              byte_d   = data_pad[{grant_q, 3'b000} +: 8];
              locked_d = !last_pad[grant_q];
              state_d  = StAccept;
            end
          end else if (tmo_q == TmoLast) begin
            locked_d = 1'b0;
            evt_d    = 1'b1;
            tmo_d    = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (sel_found && !is_transmitting) begin
          grant_d  = sel_idx;
          rr_d     = sel_idx;
          byte_d   = data_pad[{sel_idx, 3'b000} +: 8];
          locked_d = !last_pad[sel_idx];
          state_d  = StAccept;
        end
      end
      StAccept:    state_d = StPulse;
      StPulse:     state_d = StWaitStart;
      StWaitStart: state_d = StWaitDone;
      StWaitDone: begin
        if (!is_transmitting) begin
          gap_d   = '0;
          state_d = (CHAR_GAP == 0) ? StIdle : StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_q     <= RrInit;
      byte_q   <= 8'h00;
      locked_q <= 1'b0;
      gap_q    <= '0;
      tmo_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      byte_q   <= byte_d;
      locked_q <= locked_d;
      gap_q    <= gap_d;
      tmo_q    <= tmo_d;
      evt_q    <= evt_d;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
    assign req_ready[i] = (state_q == StAccept) && (grant_q == 3'(i));
  end

  assign transmit    = (state_q == StPulse);
  assign tx_byte     = byte_q;
  assign grant_id    = grant_q;
  assign locked      = locked_q;
  assign busy        = (state_q != StIdle) || locked_q;
  assign timeout_evt = evt_q;

endmodule
